circle_segment_gen: RTL and testbench

Runtime circle-outline generator for the Bresenham line engine. It replaces fixed, precomputed circle coordinate tables with a sequential engine. Given a centre, a radius and a start pulse, it computes N_SEG polygon vertices from a trig LUT. It then streams the closed outline as N_SEG line segments (x0,y0)->(x1,y1) over a valid/ready handshake into the line-drawing FSM.

---
 rtl/circle_pkg.sv | 21 ++
 rtl/circle_trig_lut.sv | 91 +++++++++
 rtl/circle_segment_gen.sv | 181 ++++++++++++++++++
 tb/tb_circle_segment_gen.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/circle_pkg.sv
// Shared constants, types and parameter checks for the circle outline generator.
package circle_pkg;

  localparam int unsigned TRIG_FRAC       = 14;
  localparam int unsigned TRIG_W          = 16;
  localparam int unsigned COORD_W_DEFAULT = 11;

  typedef logic [COORD_W_DEFAULT-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ADD,
    EMIT
  } state_t;

  function automatic bit n_seg_legal(input int unsigned n);
    return (n == 4) || (n == 8) || (n == 16) || (n == 36) || (n == 64);
  endfunction

endpackage

// File: rtl/circle_trig_lut.sv
// Combinational Q1.14 cos/sin lookup for vertex k of an N_SEG-gon.
module circle_trig_lut import circle_pkg::*; #(
  parameter int unsigned N_SEG = 36
) (
  input  logic [$clog2(N_SEG)-1:0] idx,
  output logic signed [TRIG_W-1:0] cos_val,
  output logic signed [TRIG_W-1:0] sin_val
);

  // 36 steps of 10 degrees, or a 64-step grid shared by all power-of-two counts.
  localparam int unsigned GRID   = (N_SEG == 36) ? 36 : 64;
  localparam int unsigned QTR    = GRID / 4;
  localparam int unsigned STRIDE = GRID / N_SEG;

  int unsigned       a_cos;
  int unsigned       a_sin;
  logic [TRIG_W-1:0] mag_cos;
  logic [TRIG_W-1:0] mag_sin;

  function automatic int unsigned fold_idx(input int unsigned a);
    if (a <= QTR)          return a;
    else if (a <= 2 * QTR) return 2 * QTR - a;
    else if (a <= 3 * QTR) return a - 2 * QTR;
    else                   return GRID - a;
  endfunction

  function automatic logic fold_neg(input int unsigned a);
    return (a > QTR) && (a < 3 * QTR);
  endfunction

  // sin(theta) is read as cos(theta - 90 degrees) from the same quarter table.
  always_comb begin
    a_cos = 32'(idx) * STRIDE;
    a_sin = (a_cos >= QTR) ? a_cos - QTR : a_cos + GRID - QTR;
  end

  if (N_SEG == 36) begin : g_grid36
    function automatic logic [TRIG_W-1:0] quarter(input int unsigned q);
      case (q)
        0:       return 16'd16384;
        1:       return 16'd16135;
        2:       return 16'd15396;
        3:       return 16'd14189;
        4:       return 16'd12551;
        5:       return 16'd10531;
        6:       return 16'd8192;
        7:       return 16'd5604;
        8:       return 16'd2845;
        default: return '0;
      endcase
    endfunction

    always_comb begin
      mag_cos = quarter(fold_idx(a_cos));
      mag_sin = quarter(fold_idx(a_sin));
    end
  end else begin : g_grid64
    function automatic logic [TRIG_W-1:0] quarter(input int unsigned q);
      case (q)
        0:       return 16'd16384;
        1:       return 16'd16305;
        2:       return 16'd16069;
        3:       return 16'd15678;
        4:       return 16'd15137;
        5:       return 16'd14449;
        6:       return 16'd13623;
        7:       return 16'd12665;
        8:       return 16'd11585;
        9:       return 16'd10394;
        10:      return 16'd9102;
        11:      return 16'd7723;
        12:      return 16'd6270;
        13:      return 16'd4756;
        14:      return 16'd3196;
        15:      return 16'd1606;
        default: return '0;
      endcase
    endfunction

    always_comb begin
      mag_cos = quarter(fold_idx(a_cos));
      mag_sin = quarter(fold_idx(a_sin));
    end
  end

  always_comb begin
    cos_val = fold_neg(a_cos) ? -$signed(mag_cos) : $signed(mag_cos);
    sin_val = fold_neg(a_sin) ? -$signed(mag_sin) : $signed(mag_sin);
  end

endmodule

// File: rtl/circle_segment_gen.sv
// Sequential circle-outline generator: computes polygon vertices from a trig LUT
// and streams the closed outline as line segments over valid/ready.
module circle_segment_gen import circle_pkg::*; #(
  parameter int unsigned COORD_W = 11,
  parameter int unsigned N_SEG   = 36
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [COORD_W-1:0]       cx,
  input  logic [COORD_W-1:0]       cy,
  input  logic [COORD_W-1:0]       radius,
  output logic                     seg_valid,
  input  logic                     seg_ready,
  output logic [COORD_W-1:0]       x0,
  output logic [COORD_W-1:0]       y0,
  output logic [COORD_W-1:0]       x1,
  output logic [COORD_W-1:0]       y1,
  output logic [$clog2(N_SEG)-1:0] seg_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned IDX_W  = $clog2(N_SEG);
  localparam int unsigned PROD_W = COORD_W + 17;
  localparam int unsigned SUM_W  = COORD_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SEG - 1);
  localparam logic [IDX_W-1:0] WRAP_IDX = IDX_W'(N_SEG - 2);
  localparam logic signed [PROD_W-1:0] ROUND_HALF = PROD_W'(2 ** (TRIG_FRAC - 1));

  if (!n_seg_legal(N_SEG)) begin : g_bad_n_seg
    $error("circle_segment_gen: N_SEG must be one of 4, 8, 16, 36, 64");
  end

  state_t state;
  state_t state_n;

  logic [COORD_W-1:0]       cx_r;
  logic [COORD_W-1:0]       cy_r;
  logic [COORD_W-1:0]       rad_r;
  logic [IDX_W-1:0]         vidx;
  logic                     have_first;
  logic                     bubble;
  logic [COORD_W-1:0]       first_x;
  logic [COORD_W-1:0]       first_y;
  logic signed [PROD_W-1:0] prod_x;
  logic signed [PROD_W-1:0] prod_y;
  logic signed [TRIG_W-1:0] cos_val;
  logic signed [TRIG_W-1:0] sin_val;
  logic signed [PROD_W-1:0] rad_ext;
  logic signed [PROD_W-1:0] cos_ext;
  logic signed [PROD_W-1:0] sin_ext;
  logic [COORD_W-1:0]       vert_x;
  logic [COORD_W-1:0]       vert_y;

  circle_trig_lut #(
    .N_SEG(N_SEG)
  ) u_lut (
    .idx    (vidx),
    .cos_val(cos_val),
    .sin_val(sin_val)
  );

  // Round-half-up the Q1.14 product, offset by the centre, clamp to screen.
  function automatic logic [COORD_W-1:0] place(
    input logic signed [PROD_W-1:0] prod,
    input logic [COORD_W-1:0]       centre
  );
    logic signed [PROD_W-1:0] rounded;
    logic signed [SUM_W-1:0]  sum;
    rounded = (prod + ROUND_HALF) >>> TRIG_FRAC;
    sum     = SUM_W'(rounded) + $signed({2'b00, centre});
    if (sum[SUM_W-1])      return '0;
    else if (sum[SUM_W-2]) return '1;
    else                   return sum[COORD_W-1:0];
  endfunction

  always_comb begin
    rad_ext = PROD_W'($signed({1'b0, rad_r}));
    cos_ext = PROD_W'(cos_val);
    sin_ext = PROD_W'(sin_val);
    vert_x  = place(prod_x, cx_r);
    vert_y  = place(prod_y, cy_r);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = MUL;
      MUL:     state_n = ADD;
      ADD:     state_n = have_first ? EMIT : MUL;
      EMIT:    if (seg_ready) state_n = (seg_idx == LAST_IDX) ? IDLE : MUL;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cx_r       <= '0;
      cy_r       <= '0;
      rad_r      <= '0;
      vidx       <= '0;
      have_first <= 1'b0;
      bubble     <= 1'b0;
      first_x    <= '0;
      first_y    <= '0;
      prod_x     <= '0;
      prod_y     <= '0;
      x0         <= '0;
      y0         <= '0;
      x1         <= '0;
      y1         <= '0;
      seg_idx    <= '0;
      seg_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cx_r       <= cx;
            cy_r       <= cy;
            rad_r      <= radius;
            vidx       <= '0;
            have_first <= 1'b0;
            bubble     <= 1'b0;
            seg_idx    <= '0;
            busy       <= 1'b1;
          end
        end
        MUL: begin
          prod_x <= rad_ext * cos_ext;
          prod_y <= rad_ext * sin_ext;
        end
        ADD: begin
          // In the closing bubble the LUT result is dropped; x1/y1 already hold v_first.
          if (!bubble) begin
            vidx <= vidx + 1'b1;
            if (!have_first) begin
              x0         <= vert_x;
              y0         <= vert_y;
              first_x    <= vert_x;
              first_y    <= vert_y;
              have_first <= 1'b1;
            end else begin
              x1 <= vert_x;
              y1 <= vert_y;
            end
          end
          if (have_first) seg_valid <= 1'b1;
        end
        EMIT: begin
          if (seg_ready) begin
            seg_valid <= 1'b0;
            if (seg_idx == LAST_IDX) begin
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              x0      <= x1;
              y0      <= y1;
              seg_idx <= seg_idx + 1'b1;
              if (seg_idx == WRAP_IDX) begin
                x1     <= first_x;
                y1     <= first_y;
                bubble <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_circle_segment_gen.sv
// Scoreboard bench for circle_segment_gen: a 4-segment and a 36-segment instance.
module tb_circle_segment_gen;

  typedef struct packed {
    logic [10:0] x0;
    logic [10:0] y0;
    logic [10:0] x1;
    logic [10:0] y1;
    logic [5:0]  idx;
  } seg_t;

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        start_a, ready_a, valid_a, busy_a, done_a;
  logic [10:0] cx_a, cy_a, r_a, x0_a, y0_a, x1_a, y1_a;
  logic [1:0]  idx_a;

  logic        start_b, ready_b, valid_b, busy_b, done_b;
  logic [10:0] cx_b, cy_b, r_b, x0_b, y0_b, x1_b, y1_b;
  logic [5:0]  idx_b;

  seg_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  circle_segment_gen #(.COORD_W(11), .N_SEG(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a),
    .cx(cx_a), .cy(cy_a), .radius(r_a),
    .seg_valid(valid_a), .seg_ready(ready_a),
    .x0(x0_a), .y0(y0_a), .x1(x1_a), .y1(y1_a),
    .seg_idx(idx_a), .busy(busy_a), .done(done_a)
  );

  circle_segment_gen #(.COORD_W(11), .N_SEG(36)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b),
    .cx(cx_b), .cy(cy_b), .radius(r_b),
    .seg_valid(valid_b), .seg_ready(ready_b),
    .x0(x0_b), .y0(y0_b), .x1(x1_b), .y1(y1_b),
    .seg_idx(idx_b), .busy(busy_b), .done(done_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic seg_t obs_a();
    return {x0_a, y0_a, x1_a, y1_a, 4'b0000, idx_a};
  endfunction

  function automatic seg_t obs_b();
    return {x0_b, y0_b, x1_b, y1_b, idx_b};
  endfunction

  function automatic logic [10:0] exp_coord(input int c, input int r, input int k,
                                            input int n, input bit is_y);
    real    th, v;
    longint lut, p, s;
    th  = 2.0 * PI * k / n;
    v   = is_y ? $sin(th) : $cos(th);
    lut = (v >= 0.0) ? longint'($rtoi(v * 16384.0 + 0.5))
                     : -longint'($rtoi(-v * 16384.0 + 0.5));
    p   = longint'(r) * lut + 8192;
    s   = longint'(c) + (p >>> 14);
    if (s < 0)    return '0;
    if (s > 2047) return '1;
    return s[10:0];
  endfunction

  task automatic push_circle(input int ccx, input int ccy, input int rr, input int n);
    logic [10:0] vx[64];
    logic [10:0] vy[64];
    seg_t        s;
    for (int k = 0; k < n; k++) begin
      vx[k] = exp_coord(ccx, rr, k, n, 1'b0);
      vy[k] = exp_coord(ccy, rr, k, n, 1'b1);
    end
    for (int k = 0; k < n; k++) begin
      s.x0  = vx[k];
      s.y0  = vy[k];
      s.x1  = vx[(k + 1) % n];
      s.y1  = vy[(k + 1) % n];
      s.idx = 6'(k);
      sb.push_back(s);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start_a = 0; ready_a = 0; cx_a = 0; cy_a = 0; r_a = 0;
    start_b = 0; ready_b = 0; cx_b = 0; cy_b = 0; r_b = 0;
    tick(); tick();
    total++;
    if ({valid_a, busy_a, done_a, obs_a()} !== '0) begin
      bad++; $display("FAIL reset_a got=%h want=0", {valid_a, busy_a, done_a, obs_a()});
    end
    total++;
    if ({valid_b, busy_b, done_b, obs_b()} !== '0) begin
      bad++; $display("FAIL reset_b got=%h want=0", {valid_b, busy_b, done_b, obs_b()});
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_square();
    int   cyc, first_valid, done_at;
    seg_t o, e;
    sb.delete();
    push_circle(305, 240, 115, 4);
    cx_a = 305; cy_a = 240; r_a = 115; ready_a = 1; start_a = 1;
    tick();
    start_a = 0; cyc = 1; first_valid = -1; done_at = -1;
    total++;
    if (busy_a !== 1'b1) begin bad++; $display("FAIL sq_busy got=%b want=1", busy_a); end
    while (done_at < 0 && cyc < 200) begin
      if (valid_a) begin
        if (first_valid < 0) first_valid = cyc;
        o = obs_a();
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL sq_extra got=%h", o); end
        else begin
          e = sb.pop_front();
          if (o !== e) begin bad++; $display("FAIL sq_seg got=%h want=%h", o, e); end
        end
      end
      if (done_a) done_at = cyc;
      else begin tick(); cyc++; end
    end
    total++;
    if (first_valid != 5) begin bad++; $display("FAIL sq_first_valid got=%0d want=5", first_valid); end
    total++;
    if (done_at != 15) begin bad++; $display("FAIL sq_done_latency got=%0d want=15", done_at); end
    total++;
    if (busy_a !== 1'b0) begin bad++; $display("FAIL sq_busy_end got=%b want=0", busy_a); end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sq_missing got=%0d want=0", sb.size()); end
    ready_a = 0;
  endtask

  task automatic test_backpressure();
    int          cyc;
    bit          fin, stalled, have_prev;
    seg_t        o, e, saved;
    logic [21:0] prev_end;
    sb.delete();
    push_circle(305, 240, 115, 36);
    cx_b = 305; cy_b = 240; r_b = 115; start_b = 1; ready_b = 0;
    tick();
    start_b = 0; cyc = 1; fin = 0; stalled = 0; have_prev = 0; saved = '0; prev_end = '0;
    while (!fin && cyc < 3000) begin
      o = obs_b();
      if (stalled) begin
        total++;
        if (valid_b !== 1'b1 || o !== saved) begin
          bad++; $display("FAIL bp_stable got=%b/%h want=1/%h", valid_b, o, saved);
        end
      end
      if (done_b) fin = 1;
      else begin
        ready_b = ($urandom_range(0, 2) == 0);
        if (valid_b && ready_b) begin
          total++;
          if (sb.size() == 0) begin bad++; $display("FAIL bp_extra got=%h", o); end
          else begin
            e = sb.pop_front();
            if (o !== e) begin bad++; $display("FAIL bp_seg got=%h want=%h", o, e); end
          end
          if (have_prev) begin
            total++;
            if ({o.x0, o.y0} !== prev_end) begin
              bad++; $display("FAIL bp_chain got=%h want=%h", {o.x0, o.y0}, prev_end);
            end
          end
          if (o.idx == 6'd8) begin
            total++;
            if ({o.x1, o.y1} !== {11'd305, 11'd355}) begin
              bad++; $display("FAIL bp_seg8_end got=%0d,%0d want=305,355", o.x1, o.y1);
            end
          end
          if (o.idx == 6'd35) begin
            total++;
            if ({o.x1, o.y1} !== {11'd420, 11'd240}) begin
              bad++; $display("FAIL bp_close got=%0d,%0d want=420,240", o.x1, o.y1);
            end
          end
          have_prev = 1; prev_end = {o.x1, o.y1};
        end
        stalled = valid_b && !ready_b;
        saved   = o;
        tick(); cyc++;
      end
    end
    total++;
    if (!fin || sb.size() != 0) begin
      bad++; $display("FAIL bp_complete got=fin%0d/left%0d want=fin1/left0", fin, sb.size());
    end
    ready_b = 0;
  endtask

  task automatic test_zero_radius();
    int   cyc;
    bit   fin;
    seg_t o, e;
    sb.delete();
    push_circle(50, 60, 0, 36);
    cx_b = 50; cy_b = 60; r_b = 0; ready_b = 1; start_b = 1;
    tick();
    start_b = 0; cyc = 1; fin = 0;
    while (!fin && cyc < 400) begin
      if (valid_b) begin
        o = obs_b();
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL zr_extra got=%h", o); end
        else begin
          e = sb.pop_front();
          if (o !== e) begin bad++; $display("FAIL zr_seg got=%h want=%h", o, e); end
        end
      end
      if (done_b) fin = 1;
      else begin tick(); cyc++; end
    end
    total++;
    if (!fin || cyc != 111) begin bad++; $display("FAIL zr_done_latency got=%0d want=111", cyc); end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL zr_missing got=%0d want=0", sb.size()); end
  endtask

  // Starts in the same cycle that the previous circle's done pulse is visible.
  task automatic test_clamp();
    int   cyc;
    bit   fin, saw_lo, saw_hi;
    seg_t o, e;
    sb.delete();
    push_circle(10, 2000, 100, 36);
    cx_b = 10; cy_b = 2000; r_b = 100; ready_b = 1; start_b = 1;
    tick();
    start_b = 0; cyc = 1; fin = 0; saw_lo = 0; saw_hi = 0;
    total++;
    if (busy_b !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b want=1", busy_b); end
    while (!fin && cyc < 400) begin
      if (valid_b) begin
        o = obs_b();
        if (o.x0 == 11'd0 || o.x1 == 11'd0) saw_lo = 1;
        if (o.y0 == 11'd2047 || o.y1 == 11'd2047) saw_hi = 1;
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL cl_extra got=%h", o); end
        else begin
          e = sb.pop_front();
          if (o !== e) begin bad++; $display("FAIL cl_seg got=%h want=%h", o, e); end
        end
      end
      if (done_b) fin = 1;
      else begin tick(); cyc++; end
    end
    total++;
    if (!saw_lo || !saw_hi) begin bad++; $display("FAIL cl_extremes got=lo%0d/hi%0d want=1/1", saw_lo, saw_hi); end
    total++;
    if (!fin || sb.size() != 0) begin bad++; $display("FAIL cl_complete got=%0d want=0", sb.size()); end
  endtask

  task automatic test_start_while_busy();
    int   cyc;
    bit   fin;
    seg_t o, e;
    tick();
    sb.delete();
    push_circle(305, 240, 115, 36);
    cx_b = 305; cy_b = 240; r_b = 115; ready_b = 1; start_b = 1;
    tick();
    start_b = 0; cyc = 1; fin = 0;
    while (!fin && cyc < 400) begin
      if (cyc == 3)  begin start_b = 1; cx_b = 900; cy_b = 100; r_b = 40; end
      if (cyc == 4)  start_b = 0;
      if (cyc == 30) start_b = 1;
      if (cyc == 31) start_b = 0;
      if (valid_b) begin
        o = obs_b();
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL sb_extra got=%h", o); end
        else begin
          e = sb.pop_front();
          if (o !== e) begin bad++; $display("FAIL sb_seg got=%h want=%h", o, e); end
        end
      end
      if (done_b) fin = 1;
      else begin tick(); cyc++; end
    end
    total++;
    if (!fin || sb.size() != 0) begin bad++; $display("FAIL sb_complete got=%0d want=0", sb.size()); end
    tick(); tick();
    total++;
    if ({busy_b, valid_b} !== 2'b00) begin bad++; $display("FAIL sb_idle got=%b want=00", {busy_b, valid_b}); end
  endtask

  task automatic test_reset_mid();
    int   cyc;
    bit   fin, hit;
    seg_t o, e;
    cx_b = 305; cy_b = 240; r_b = 115; ready_b = 1; start_b = 1;
    tick();
    start_b = 0; cyc = 1; hit = 0;
    while (!hit && cyc < 400) begin
      if (valid_b && idx_b == 6'd5) hit = 1;
      else begin tick(); cyc++; end
    end
    ready_b = 0; reset_n = 0;
    tick();
    reset_n = 1;
    total++;
    if (!hit || {valid_b, busy_b, done_b, obs_b()} !== '0) begin
      bad++; $display("FAIL rm_clear got=%0d/%h want=1/0", hit, {valid_b, busy_b, done_b, obs_b()});
    end
    tick();
    sb.delete();
    push_circle(700, 500, 200, 36);
    cx_b = 700; cy_b = 500; r_b = 200; ready_b = 1; start_b = 1;
    tick();
    start_b = 0; cyc = 1; fin = 0;
    while (!fin && cyc < 400) begin
      if (valid_b) begin
        o = obs_b();
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL rm_extra got=%h", o); end
        else begin
          e = sb.pop_front();
          if (o !== e) begin bad++; $display("FAIL rm_seg got=%h want=%h", o, e); end
        end
      end
      if (done_b) fin = 1;
      else begin tick(); cyc++; end
    end
    total++;
    if (!fin || sb.size() != 0) begin bad++; $display("FAIL rm_complete got=%0d want=0", sb.size()); end
    ready_b = 0;
  endtask

  initial begin
    test_reset();
    test_square();
    test_backpressure();
    test_zero_radius();
    test_clamp();
    test_start_while_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
